irq_sb_arbiter: RTL and testbench

//  Interrupt controller between the system-bus peripherals (switches, buttons, UART, timer) and the core.
//  - Collects level interrupt requests and masks them.
//  - Picks one source and raises a single core interrupt carrying a cause code.
//  - Routes the core's return strobe back to the served peripheral as its interrupt_return_i pulse.
//  - Mask and status registers are reachable through the standard system-bus peripheral port.

---
 rtl/irq_sb_arbiter.sv | 144 ++++++++++++++
 tb/tb_irq_sb_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sb_arbiter.sv
// +--------------------------------------------------------------------------+
// | irq_sb_arbiter: masks peripheral level IRQs, arbitrates one to the core, |
// | routes the return strobe back. Option macro: IRQ_ROUND_ROBIN_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module irq_sb_arbiter #(
  parameter int N_SRC = 8,
  parameter int SRC_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             write_enable_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      write_data_i,
  output logic [31:0]      read_data_o,
  input  logic [N_SRC-1:0] irq_req_i,
  output logic [N_SRC-1:0] irq_ret_o,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  input  logic             irq_ret_i
);

  localparam logic [31:0] ADDR_MASK    = 32'h0000_0000;
  localparam logic [31:0] ADDR_PENDING = 32'h0000_0004;
  localparam logic [31:0] ADDR_CAUSE   = 32'h0000_0008;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SERVE  = 2'd1,
    S_RETURN = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] pending;
  logic [SRC_W-1:0] sel;
  logic [SRC_W-1:0] win;
  logic             unused_wdata;

  assign pending      = irq_req_i & mask;
  assign unused_wdata = ^write_data_i[31:N_SRC];

`ifdef IRQ_ROUND_ROBIN_EN
  localparam int IW = SRC_W + 1;

  logic [SRC_W-1:0] rr_ptr;
  logic [15:0]      pending_16;
  logic [SRC_W:0]   rr_idx;
  logic             found;

  assign pending_16 = 16'(pending);

  // Walk N_SRC positions starting at rr_ptr, wrapping past the last source.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      rr_idx = {1'b0, rr_ptr} + IW'(k);
      if (rr_idx >= IW'(N_SRC)) rr_idx = rr_idx - IW'(N_SRC);
      if (!found && pending_16[rr_idx[SRC_W-1:0]]) begin
        found = 1'b1;
        win   = rr_idx[SRC_W-1:0];
      end
    end
  end
`else
  // Descending scan so the lowest pending index is the last assignment.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i]) win = SRC_W'(i);
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      sel         <= '0;
      irq_o       <= 1'b0;
      irq_cause_o <= '0;
      irq_ret_o   <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          irq_ret_o <= '0;
          if (|pending) begin
            sel         <= win;
            irq_o       <= 1'b1;
            irq_cause_o <= {1'b1, 27'b0, win};
            state       <= S_SERVE;
          end
        end
        S_SERVE: begin
          // Service is committed: mask or request changes here do not abort it.
          if (irq_ret_i) begin
            irq_o       <= 1'b0;
            irq_cause_o <= '0;
            irq_ret_o   <= N_SRC'(1) << sel;
            state       <= S_RETURN;
          end
        end
        S_RETURN: begin
          irq_ret_o <= '0;
          state     <= S_IDLE;
`ifdef IRQ_ROUND_ROBIN_EN
          rr_ptr    <= (sel == SRC_W'(N_SRC - 1)) ? '0 : sel + 1'b1;
`endif
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask        <= '0;
      read_data_o <= '0;
    end else if (req_i) begin
      if (write_enable_i) begin
        if (addr_i == ADDR_MASK) mask <= write_data_i[N_SRC-1:0];
      end else begin
        case (addr_i)
          ADDR_MASK:    read_data_o <= 32'(mask);
          ADDR_PENDING: read_data_o <= 32'(pending);
          ADDR_CAUSE:   read_data_o <= irq_cause_o;
          default:      read_data_o <= '0;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_sb_arbiter.sv
// Scoreboard bench for irq_sb_arbiter: stimulus queues expected events, a
// negedge monitor matches reads, IRQ raises and return pulses against them.
`default_nettype none

module tb_irq_sb_arbiter;

  localparam int KIND_READ = 0;
  localparam int KIND_IRQ  = 1;
  localparam int KIND_RET  = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  irq_req;
  logic [7:0]  irq_ret;
  logic        irq;
  logic [31:0] cause;
  logic        ret_in;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        rd_pend = 1'b0;
  logic        rst_seen = 1'b0;
  logic        prev_irq = 1'b0;
  logic [31:0] prev_cause = '0;

  irq_sb_arbiter #(.N_SRC(8), .SRC_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .write_enable_i (we),
    .addr_i         (addr),
    .write_data_i   (wdata),
    .read_data_o    (rdata),
    .irq_req_i      (irq_req),
    .irq_ret_o      (irq_ret),
    .irq_o          (irq),
    .irq_cause_o    (cause),
    .irq_ret_i      (ret_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_pend  <= req && !we && !rst;
    rst_seen <= rst;
  end

  function automatic string kname(int k);
    if (k == KIND_READ) return "read_data";
    if (k == KIND_IRQ)  return "irq_cause";
    return "irq_ret";
  endfunction

  // Match the oldest queued expectation of the same kind; value and cycle must agree.
  task automatic take(int kind, logic [31:0] act);
    int idx;
    exp_t e;
    idx = -1;
    n_tests++;
    for (int i = 0; i < q.size(); i++) begin
      if (idx < 0 && q[i].kind == kind) idx = i;
    end
    if (idx < 0) begin
      n_fail++;
      $display("FAIL %s unexpected event: actual=%h at cycle %0d, required none", kname(kind), act, cyc);
    end else begin
      e = q[idx];
      q.delete(idx);
      if (e.val !== act || e.cyc != cyc)
        begin
          n_fail++;
          $display("FAIL %s: actual=%h at cycle %0d, required=%h at cycle %0d",
                   kname(kind), act, cyc, e.val, e.cyc);
        end
    end
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      n_tests++;
      if (irq !== 1'b0 || irq_ret !== 8'h00 || cause !== 32'h0 || rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state: actual irq=%b ret=%h cause=%h rdata=%h, required all zero",
                 irq, irq_ret, cause, rdata);
      end
    end else begin
      if (rd_pend) take(KIND_READ, rdata);
      if (irq && !prev_irq) take(KIND_IRQ, cause);
      n_tests++;
      if (irq && prev_irq && cause !== prev_cause) begin
        n_fail++;
        $display("FAIL cause_stable: actual=%h, required=%h", cause, prev_cause);
      end else if (!irq && cause !== 32'h0) begin
        n_fail++;
        $display("FAIL cause_idle: actual=%h, required=00000000", cause);
      end
      if (irq_ret !== 8'h00) take(KIND_RET, {24'h0, irq_ret});
      while (q.size() > 0 && q[0].cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s missing: actual none by cycle %0d, required=%h at cycle %0d",
                 kname(q[0].kind), cyc, q[0].val, q[0].cyc);
        void'(q.pop_front());
      end
    end
    prev_irq   = irq;
    prev_cause = cause;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(int kind, logic [31:0] val, int delay);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = cyc + delay;
    q.push_back(e);
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(logic [31:0] a, logic [31:0] exp_val);
    expect_ev(KIND_READ, exp_val, 1);
    req = 1'b1; we = 1'b0; addr = a;
    tick();
    req = 1'b0;
  endtask

  // Core return strobe, then the peripheral drops its request during RETURN.
  task automatic do_return(logic [7:0] vec);
    expect_ev(KIND_RET, {24'h0, vec}, 1);
    ret_in = 1'b1;
    tick();
    ret_in  = 1'b0;
    irq_req = irq_req & ~vec;
    tick();
  endtask

  initial begin
    logic [31:0] first_cause, second_cause;
    logic [7:0]  first_vec, second_vec;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    irq_req = '0; ret_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset register contents; stray return strobe in IDLE.
    bus_read(32'h0, 32'h0);
    bus_read(32'h4, 32'h0);
    bus_read(32'h8, 32'h0);
    ret_in = 1'b1;
    tick();
    ret_in = 1'b0;
    tick();

    // Single source 0.
    bus_write(32'h0, 32'h01);
    irq_req = 8'h01;
    expect_ev(KIND_IRQ, 32'h8000_0000, 1);
    tick();
    bus_read(32'h8, 32'h8000_0000);
    bus_read(32'h4, 32'h1);
    do_return(8'h01);
    tick();
    tick();

    // Two held sources.
    bus_write(32'h0, 32'hFF);
    irq_req = 8'h24;
    expect_ev(KIND_IRQ, 32'h8000_0002, 1);
    tick();
    tick();
    do_return(8'h04);
    expect_ev(KIND_IRQ, 32'h8000_0005, 1);
    tick();
    do_return(8'h20);
`ifdef IRQ_ROUND_ROBIN_EN
    first_cause = 32'h8000_0007; first_vec = 8'h80;
    second_cause = 32'h8000_0002; second_vec = 8'h04;
`else
    first_cause = 32'h8000_0002; first_vec = 8'h04;
    second_cause = 32'h8000_0007; second_vec = 8'h80;
`endif
    irq_req = 8'h84;
    expect_ev(KIND_IRQ, first_cause, 1);
    tick();
    do_return(first_vec);
    expect_ev(KIND_IRQ, second_cause, 1);
    tick();
    do_return(second_vec);

    // Masked request stays pending; RO / unmapped writes ignored.
    bus_write(32'h0, 32'h00);
    irq_req = 8'h08;
    repeat (3) tick();
    bus_read(32'h4, 32'h0);
    bus_write(32'h4, 32'hFF);
    bus_write(32'h10, 32'hFF);
    tick();
    bus_read(32'h0, 32'h0);
    bus_read(32'hC, 32'h0);
    expect_ev(KIND_IRQ, 32'h8000_0003, 2);
    bus_write(32'h0, 32'h08);
    bus_read(32'h0, 32'h08);
    do_return(8'h08);

    // Mask cleared and new request during SERVE of source 1.
    bus_write(32'h0, 32'h02);
    irq_req = 8'h02;
    expect_ev(KIND_IRQ, 32'h8000_0001, 1);
    tick();
    irq_req = 8'h03;
    bus_write(32'h0, 32'h00);
    tick();
    tick();
    bus_read(32'h8, 32'h8000_0001);
    do_return(8'h02);
    repeat (3) tick();
    bus_read(32'h4, 32'h0);
    irq_req = 8'h00;

    // Reset in SERVE together with a return strobe.
    bus_write(32'h0, 32'h10);
    irq_req = 8'h10;
    expect_ev(KIND_IRQ, 32'h8000_0004, 1);
    tick();
    tick();
    rst = 1'b1;
    ret_in = 1'b1;
    tick();
    rst = 1'b0;
    ret_in = 1'b0;
    tick();
    tick();
    bus_read(32'h0, 32'h0);
    repeat (3) tick();
    irq_req = 8'h00;
    repeat (4) tick();

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_empty: actual=%0d outstanding, required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
